// File: rtl/mitchell_antilog_pipe.sv
// Mitchell antilog: turns a log-domain (characteristic, mantissa-sum) pair back into a
// linear product, floor((1.f) * 2^K), through a two-stage valid/ready pipeline.
module mitchell_antilog_pipe #(
    parameter int FRAC_W = 15,
    parameter int CHAR_W = 5,
    parameter int OUT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_zero,
    input  logic [CHAR_W-1:0] in_char,
    input  logic [FRAC_W:0]   in_fsum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_ovf
);

    localparam int K_W  = CHAR_W + 1;
    localparam int SH_W = FRAC_W + 1 + OUT_W;

    // stage 1: normalised exponent, fraction, zero flag
    logic              s1_valid_q, s1_valid_d;
    logic [K_W-1:0]    s1_k_q, s1_k_d;
    logic [FRAC_W-1:0] s1_f_q, s1_f_d;
    logic              s1_zero_q, s1_zero_d;

    // stage 2 is the output register itself
    logic              out_valid_q, out_valid_d;
    logic [OUT_W-1:0]  out_data_q, out_data_d;
    logic              out_ovf_q, out_ovf_d;

    logic              s2_free;
    logic              s1_adv;
    logic              in_acc;
    logic [SH_W-1:0]   shifted;
    logic [OUT_W-1:0]  lin_val;
    logic              sat;

    assign s2_free  = !out_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_free;
    assign in_ready = !s1_valid_q || s1_adv;
    assign in_acc   = in_valid && in_ready;

    // A mantissa sum >= 1.0 carries into the exponent; the fraction keeps its low bits.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_k_d     = s1_k_q;
        s1_f_d     = s1_f_q;
        s1_zero_d  = s1_zero_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (in_acc) begin
            s1_k_d    = K_W'(in_char) + K_W'(in_fsum[FRAC_W]);
            s1_f_d    = in_fsum[FRAC_W-1:0];
            s1_zero_d = in_zero;
        end
    end

    // Leading one lands at bit K; the window above bit FRAC_W is the integer part.
    always_comb begin
        shifted = {{OUT_W{1'b0}}, 1'b1, s1_f_q} << s1_k_q;
        lin_val = OUT_W'(shifted >> FRAC_W);
        sat     = 32'(s1_k_q) > 32'(OUT_W - 1);
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        if (s2_free) begin
            out_valid_d = s1_valid_q;
        end
        if (s1_adv) begin
            if (s1_zero_q) begin
                out_data_d = '0;
                out_ovf_d  = 1'b0;
            end else if (sat) begin
                out_data_d = '1;
                out_ovf_d  = 1'b1;
            end else begin
                out_data_d = lin_val;
                out_ovf_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_k_q      <= '0;
            s1_f_q      <= '0;
            s1_zero_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_k_q      <= s1_k_d;
            s1_f_q      <= s1_f_d;
            s1_zero_q   <= s1_zero_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mitchell_antilog_pipe.sv
// Bench for mitchell_antilog_pipe: directed vectors with literal expectations plus an
// arithmetic reference model and in-order scoreboard checked on every output transfer.
module tb_mitchell_antilog_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_zero = 1'b0;
    logic [4:0]  in_char = '0;
    logic [15:0] in_fsum = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_ovf;

    int n_vec = 0;
    int n_err = 0;
    int n_out = 0;

    typedef struct {
        logic [31:0] d;
        logic        o;
    } exp_t;
    exp_t sb[$];

    mitchell_antilog_pipe #(.FRAC_W(15), .CHAR_W(5), .OUT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_zero(in_zero), .in_char(in_char), .in_fsum(in_fsum),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    // Reference: (1 + f/2^15) * 2^K floored, with carry from the integer bit of the sum.
    function automatic void model(input logic z, input logic [4:0] c, input logic [15:0] fs,
                                  output logic [31:0] d, output logic o);
        int     k;
        longint m;
        k = int'(c) + int'(fs[15]);
        if (z) begin
            d = 32'd0; o = 1'b0;
        end else if (k > 31) begin
            d = 32'hFFFF_FFFF; o = 1'b1;
        end else begin
            m = ((longint'(32768) + longint'(fs[14:0])) * (longint'(1) << k)) / 32768;
            d = m[31:0]; o = 1'b0;
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    logic        stall_q = 1'b0;
    logic [31:0] hold_d = '0;
    logic        hold_o = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_data", out_data, hold_d);
                chk("hold_ovf", {31'd0, out_ovf}, {31'd0, hold_o});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL spurious_out: got %h want no beat", out_data);
                end else begin
                    e = sb.pop_front();
                    chk("model_data", out_data, e.d);
                    chk("model_ovf", {31'd0, out_ovf}, {31'd0, e.o});
                    n_out++;
                end
            end
            if (in_valid && in_ready) begin
                model(in_zero, in_char, in_fsum, e.d, e.o);
                sb.push_back(e);
            end
            stall_q = out_valid && !out_ready;
            hold_d  = out_data;
            hold_o  = out_ovf;
        end
    end

    // Present one beat into an empty pipe and check the exact 2-cycle latency and value.
    task automatic single(input string nm, input logic z, input logic [4:0] c,
                          input logic [15:0] f, input logic [31:0] ed, input logic eo);
        in_valid = 1'b1; in_zero = z; in_char = c; in_fsum = f;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({nm, "_lat1"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk({nm, "_vld"}, {31'd0, out_valid}, 32'd1);
        chk({nm, "_data"}, out_data, ed);
        chk({nm, "_ovf"}, {31'd0, out_ovf}, {31'd0, eo});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] md;
        logic        mo;
        int          idx;
        int          w;
        logic        acc;

        model(1'b0, 5'd3, 16'h4000, md, mo);   chk("pin_plain", md, 32'd12);
        model(1'b0, 5'd7, 16'hC000, md, mo);   chk("pin_carry", md, 32'd384);
        model(1'b0, 5'd31, 16'h8000, md, mo);  chk("pin_ovf", {31'd0, mo}, 32'd1);

        #3;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_ovf", {31'd0, out_ovf}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        single("plain3",  1'b0, 5'd3,  16'h4000, 32'd12,         1'b0);
        single("plain0",  1'b0, 5'd0,  16'h4000, 32'd1,          1'b0);
        single("carry",   1'b0, 5'd7,  16'hC000, 32'd384,        1'b0);
        single("top",     1'b0, 5'd31, 16'h7FFF, 32'hFFFF_0000,  1'b0);
        single("sat",     1'b0, 5'd31, 16'h8000, 32'hFFFF_FFFF,  1'b1);
        single("zero",    1'b1, 5'd20, 16'h1234, 32'd0,          1'b0);
        single("exact1",  1'b0, 5'd0,  16'h0000, 32'd1,          1'b0);
        single("edge31",  1'b0, 5'd30, 16'h8000, 32'h8000_0000,  1'b0);

        for (int i = 0; i < 12; i++) begin
            in_valid = (i < 8);
            in_zero  = (i == 5);
            in_char  = 5'(i * 3);
            in_fsum  = 16'(i * 16'h1357);
            @(posedge clk); #1;
            chk("stream_vld", {31'd0, out_valid}, {31'd0, (i >= 1 && i <= 8)});
        end
        in_valid = 1'b0;

        idx = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            out_ready = !(cyc >= 2 && cyc <= 5);
            in_valid  = (idx < 8);
            in_zero   = 1'b0;
            in_char   = 5'(idx + 10);
            in_fsum   = 16'(16'h8000 ^ (idx * 16'h0F0F));
            #1;
            if (cyc >= 2 && cyc <= 5) chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_all_accepted", 32'(idx), 32'd8);
        w = 0;
        while (sb.size() != 0 && w < 50) begin
            @(posedge clk); w++;
        end
        #1 chk("bp_drained", 32'(sb.size()), 32'd0);
        chk("total_out", 32'(n_out), 32'd24);

        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1; in_zero = 1'b0; in_char = 5'd4; in_fsum = 16'h2000;
        @(posedge clk); #1;
        in_char = 5'd6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rst_mid_full", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_data", out_data, 32'd0);
        chk("rst_mid_ovf", {31'd0, out_ovf}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1 chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("rst_no_ghost", {31'd0, out_valid}, 32'd0);
        end
        single("post_rst", 1'b0, 5'd10, 16'h4000, 32'd1536, 1'b0);
        @(posedge clk); #1;
        chk("post_rst_sb", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
